scalar_entropy_source: RTL

Parametrised entropy-to-scalar front end for the ECDHE key generator. It takes a raw noise bit stream from the ring-oscillator array and runs continuous health tests on it: a repetition-count test and an adaptive-proportion test. It then Von Neumann de-biases the stream into a KEY_W-bit candidate and rejection-samples that candidate into [1, ORDER-1]. The accepted private scalar is delivered on a valid/ready handshake to the keygen FSM.

---
 rtl/scalar_entropy_source.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/scalar_entropy_source.sv
// rtl/scalar_entropy_source.sv - health-tested, Von Neumann de-biased, rejection-sampled private scalar source
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req                   start request (taken in IDLE)
//   raw_bit, raw_valid    raw ring-oscillator noise stream
//   key_o, key_valid      accepted scalar in [1, ORDER-1]; key_o is zero unless key_valid
//   key_ready             consumer accepts the scalar
//   busy                  collecting, checking or presenting a scalar
//   fail, fail_code       sticky failure: 1 repetition, 2 proportion, 3 retries exhausted
//   clear_fail            leaves FAIL and clears health/retry state
module scalar_entropy_source #(
    parameter int              KEY_W     = 256,
    parameter logic [KEY_W-1:0] ORDER    = 256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551,
    parameter int              REP_LIMIT = 32,
    parameter int              APT_WIN   = 512,
    parameter int              APT_LIMIT = 410,
    parameter int              MAX_RETRY = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req,
    input  logic             raw_bit,
    input  logic             raw_valid,
    output logic [KEY_W-1:0] key_o,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             busy,
    output logic             fail,
    output logic [1:0]       fail_code,
    input  logic             clear_fail
);

    localparam int BW  = $clog2(KEY_W + 1);
    localparam int RCW = $clog2(REP_LIMIT + 1);
    localparam int AIW = $clog2(APT_WIN);
    localparam int ACW = $clog2(APT_WIN + 1);
    localparam int TW  = $clog2(MAX_RETRY + 1);

    localparam logic [BW-1:0]  LAST_BIT   = BW'(KEY_W - 1);
    localparam logic [RCW-1:0] REP_LIM_C  = RCW'(REP_LIMIT);
    localparam logic [AIW-1:0] APT_LAST_C = AIW'(APT_WIN - 1);
    localparam logic [ACW-1:0] APT_LIM_C  = ACW'(APT_LIMIT);
    localparam logic [TW-1:0]  RETRY_LAST = TW'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_OUT,
        S_FAIL
    } state_t;

    state_t state, state_nxt;

    logic             last_bit;
    logic [RCW-1:0]   rep_cnt;
    logic [AIW-1:0]   apt_idx;
    logic             apt_ref;
    logic [ACW-1:0]   apt_cnt;
    logic             pair_full;
    logic             pair_bit;
    logic [BW-1:0]    bit_cnt;
    logic [KEY_W-1:0] cand;
    logic [TW-1:0]    retry_cnt;

    logic             health_en;
    logic [RCW-1:0]   rep_nxt;
    logic             apt_first;
    logic [ACW-1:0]   apt_nxt;
    logic             rep_trip;
    logic             apt_trip;
    logic             health_trip;
    logic             vn_emit;
    logic             last_emit;
    logic             cand_ok;
    logic             enter_collect;

    // Health tests see every valid raw bit outside FAIL, whether or not it is used for the key.
    assign health_en   = raw_valid && (state != S_FAIL);
    // rep_cnt==0 only before the first bit after reset/clear, so that bit starts a fresh run.
    assign rep_nxt     = (rep_cnt == '0 || raw_bit != last_bit) ? RCW'(1) : rep_cnt + RCW'(1);
    assign apt_first   = (apt_idx == '0);
    assign apt_nxt     = apt_first ? ACW'(1)
                       : ((raw_bit == apt_ref) ? apt_cnt + ACW'(1) : apt_cnt);
    assign rep_trip    = health_en && (rep_nxt == REP_LIM_C);
    assign apt_trip    = health_en && (apt_nxt == APT_LIM_C);
    assign health_trip = rep_trip || apt_trip;

    // A pair emits its first bit only when the two bits differ.
    assign vn_emit     = (state == S_COLLECT) && raw_valid && pair_full && (pair_bit != raw_bit);
    assign last_emit   = vn_emit && (bit_cnt == LAST_BIT);
    assign cand_ok     = (cand != '0) && (cand < ORDER);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (health_trip)  state_nxt = S_FAIL;
                else if (req)     state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (health_trip)    state_nxt = S_FAIL;
                else if (last_emit) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (health_trip)                  state_nxt = S_FAIL;
                else if (cand_ok)                 state_nxt = S_OUT;
                else if (retry_cnt == RETRY_LAST) state_nxt = S_FAIL;
                else                              state_nxt = S_COLLECT;
            end
            S_OUT: begin
                if (health_trip)    state_nxt = S_FAIL;
                else if (key_ready) state_nxt = S_IDLE;
            end
            S_FAIL: begin
                if (clear_fail) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign enter_collect = (state_nxt == S_COLLECT) && (state != S_COLLECT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_bit <= 1'b0;
            rep_cnt  <= '0;
            apt_idx  <= '0;
            apt_ref  <= 1'b0;
            apt_cnt  <= '0;
        end else if (state == S_FAIL) begin
            if (clear_fail) begin
                last_bit <= 1'b0;
                rep_cnt  <= '0;
                apt_idx  <= '0;
                apt_ref  <= 1'b0;
                apt_cnt  <= '0;
            end
        end else if (raw_valid) begin
            last_bit <= raw_bit;
            rep_cnt  <= rep_nxt;
            apt_cnt  <= apt_nxt;
            apt_idx  <= (apt_idx == APT_LAST_C) ? '0 : apt_idx + AIW'(1);
            if (apt_first) apt_ref <= raw_bit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retry_cnt <= '0;
            fail_code <= 2'd0;
        end else begin
            if (state == S_FAIL) begin
                if (clear_fail) begin
                    retry_cnt <= '0;
                    fail_code <= 2'd0;
                end
            end else if (state == S_CHECK) begin
                retry_cnt <= cand_ok ? '0 : retry_cnt + TW'(1);
            end
            if (state != S_FAIL && state_nxt == S_FAIL)
                fail_code <= rep_trip ? 2'd1 : (apt_trip ? 2'd2 : 2'd3);
        end
    end

    // Any entry to FAIL drops the candidate, so a pending key is never presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pair_full <= 1'b0;
            pair_bit  <= 1'b0;
            bit_cnt   <= '0;
            cand      <= '0;
        end else if (state_nxt == S_FAIL || state == S_FAIL || enter_collect) begin
            pair_full <= 1'b0;
            pair_bit  <= 1'b0;
            bit_cnt   <= '0;
            cand      <= '0;
        end else if (state == S_COLLECT && raw_valid) begin
            pair_full <= !pair_full;
            if (!pair_full) pair_bit <= raw_bit;
            if (vn_emit) begin
                cand    <= {cand[KEY_W-2:0], pair_bit};
                bit_cnt <= bit_cnt + BW'(1);
            end
        end else if (state == S_OUT && key_ready) begin
            cand <= '0;
        end
    end

    assign key_valid = (state == S_OUT);
    assign key_o     = key_valid ? cand : '0;
    assign busy      = (state == S_COLLECT) || (state == S_CHECK) || (state == S_OUT);
    assign fail      = (state == S_FAIL);

endmodule
